// File: rtl/rxroutetbl_lru.sv
// rxroutetbl_lru
//   MAC learning/routing table. Source MACs offered on the RX side are
//   learned (MAC -> ingress port) through a round-robin arbiter; entries age
//   on i_tick and the least-aged entry is replaced when the table is full.
//   Lookups on the TX side return a one-hot egress mask, never the source.
// Ports
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_tick           age prescaler strobe
//   i_flush          invalidate every entry
//   RX_VALID/READY   per-port learn handshake, RX_SRCMAC[k*MACW +: MACW]
//   TX_VALID/ACK     lookup request (held until ACK) / one-cycle completion
//   TX_DSTMAC        destination MAC to route
//   TX_SRCPORT       one-hot ingress port, pruned from TX_PORT
//   TX_PORT, TX_HIT  egress mask and unicast-hit flag, valid with TX_ACK
module rxroutetbl_lru #(
  parameter int NETH  = 4,
  parameter int LGTBL = 6,
  parameter int MACW  = 48,
  parameter int AGEW  = 8,
  parameter logic [NETH-1:0] BROADCAST_PORT = {NETH{1'b1}},
  parameter logic [NETH-1:0] DEFAULT_PORT   = BROADCAST_PORT
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_flush,
  input  logic [NETH-1:0]    RX_VALID,
  output logic [NETH-1:0]    RX_READY,
  input  logic [NETH*MACW-1:0] RX_SRCMAC,
  input  logic               TX_VALID,
  output logic               TX_ACK,
  input  logic [MACW-1:0]    TX_DSTMAC,
  input  logic [NETH-1:0]    TX_SRCPORT,
  output logic [NETH-1:0]    TX_PORT,
  output logic               TX_HIT
);
  localparam int NTBL = 1 << LGTBL;
  localparam int PW   = (NETH > 1) ? $clog2(NETH) : 1;

  logic [NTBL-1:0] tbl_vld;
  logic [MACW-1:0] tbl_mac  [NTBL];
  logic [PW-1:0]   tbl_port [NTBL];
  logic [AGEW-1:0] tbl_age  [NTBL];
  logic [PW-1:0]   rr_ptr;

  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] p, input int i);
    int s;
    s = int'(p) + i;
    if (s >= NETH) s = s - NETH;
    return PW'(s);
  endfunction

  // Round-robin grant, searching from rr_ptr (the port after the last grant)
  logic          gnt_any;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] cand;
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    cand     = '0;
    RX_READY = '0;
    for (int i = 0; i < NETH; i++) begin
      cand = rr_idx(rr_ptr, i);
      if (!gnt_any && RX_VALID[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt_any) RX_READY[gnt_idx] = 1'b1;
  end

  // Learn target: existing entry, else lowest free, else least age
  logic [MACW-1:0]  lrn_mac;
  logic             lrn_en;
  logic             lm_hit, free_any;
  logic [LGTBL-1:0] lm_idx, free_idx, old_idx, wr_idx;
  logic [AGEW-1:0]  old_age;
  always_comb begin
    lrn_mac  = RX_SRCMAC[int'(gnt_idx)*MACW +: MACW];
    lrn_en   = gnt_any && !lrn_mac[MACW-8] && !i_flush;
    lm_hit   = 1'b0;
    lm_idx   = '0;
    free_any = 1'b0;
    free_idx = '0;
    old_idx  = '0;
    old_age  = '1;
    for (int i = 0; i < NTBL; i++) begin
      if (tbl_vld[i] && tbl_mac[i] == lrn_mac && !lm_hit) begin
        lm_hit = 1'b1;
        lm_idx = LGTBL'(i);
      end
      if (!tbl_vld[i] && !free_any) begin
        free_any = 1'b1;
        free_idx = LGTBL'(i);
      end
      // strict compare keeps the lowest index on ties
      if (tbl_vld[i] && tbl_age[i] < old_age) begin
        old_age = tbl_age[i];
        old_idx = LGTBL'(i);
      end
    end
    wr_idx = lm_hit ? lm_idx : (free_any ? free_idx : old_idx);
  end

  // Lookup against the table as it stands before this edge
  logic            lk_hit, lk_mcast;
  logic [PW-1:0]   lk_port;
  logic [NETH-1:0] lk_oh, lk_mask;
  always_comb begin
    lk_hit  = 1'b0;
    lk_port = '0;
    lk_oh   = '0;
    for (int i = 0; i < NTBL; i++) begin
      if (tbl_vld[i] && tbl_mac[i] == TX_DSTMAC && !lk_hit) begin
        lk_hit  = 1'b1;
        lk_port = tbl_port[i];
      end
    end
    lk_oh[lk_port] = 1'b1;
    lk_mcast = (&TX_DSTMAC) || TX_DSTMAC[MACW-8];
    if (lk_mcast)    lk_mask = BROADCAST_PORT;
    else if (lk_hit) lk_mask = lk_oh;
    else             lk_mask = DEFAULT_PORT;
    lk_mask = lk_mask & ~TX_SRCPORT;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tbl_vld <= '0;
      rr_ptr  <= '0;
      TX_ACK  <= 1'b0;
      TX_PORT <= '0;
      TX_HIT  <= 1'b0;
      for (int i = 0; i < NTBL; i++) tbl_age[i] <= '0;
    end else begin
      if (gnt_any) rr_ptr <= rr_idx(gnt_idx, 1);
      TX_ACK <= TX_VALID && !TX_ACK;
      if (TX_VALID && !TX_ACK) begin
        TX_PORT <= lk_mask;
        TX_HIT  <= lk_hit && !lk_mcast;
      end
      if (i_flush) begin
        tbl_vld <= '0;
      end else begin
        for (int i = 0; i < NTBL; i++) begin
          if (lrn_en && wr_idx == LGTBL'(i)) begin
            tbl_vld[i]  <= 1'b1;
            tbl_mac[i]  <= lrn_mac;
            tbl_port[i] <= gnt_idx;
            tbl_age[i]  <= '1;
          end else if (i_tick && tbl_vld[i]) begin
            if (tbl_age[i] <= AGEW'(1)) tbl_vld[i] <= 1'b0;
            tbl_age[i] <= tbl_age[i] - AGEW'(1);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_rxroutetbl_lru.sv
module tb_rxroutetbl_lru;
  logic         i_clk = 1'b0;
  logic         i_reset, i_tick, i_flush;
  logic [3:0]   RX_VALID;
  logic [191:0] RX_SRCMAC;
  logic         TX_VALID;
  logic [47:0]  TX_DSTMAC;
  logic [3:0]   TX_SRCPORT;
  logic [3:0]   rdy, port, rdy_a, port_a;
  logic         ack, hit, ack_a, hit_a;
  int total = 0;
  int bad = 0;

  localparam logic [47:0] MAC_A  = 48'h0011_2233_4455;
  localparam logic [47:0] MAC_B  = 48'h02AA_BBCC_DDEE;
  localparam logic [47:0] MAC_BC = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] MAC_MC = 48'h0100_5E00_0001;

  always #5 i_clk = ~i_clk;

  rxroutetbl_lru dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_tick(i_tick), .i_flush(i_flush),
    .RX_VALID(RX_VALID), .RX_READY(rdy), .RX_SRCMAC(RX_SRCMAC),
    .TX_VALID(TX_VALID), .TX_ACK(ack), .TX_DSTMAC(TX_DSTMAC),
    .TX_SRCPORT(TX_SRCPORT), .TX_PORT(port), .TX_HIT(hit));

  rxroutetbl_lru #(.AGEW(2)) dut_a (
    .i_clk(i_clk), .i_reset(i_reset), .i_tick(i_tick), .i_flush(i_flush),
    .RX_VALID(RX_VALID), .RX_READY(rdy_a), .RX_SRCMAC(RX_SRCMAC),
    .TX_VALID(TX_VALID), .TX_ACK(ack_a), .TX_DSTMAC(TX_DSTMAC),
    .TX_SRCPORT(TX_SRCPORT), .TX_PORT(port_a), .TX_HIT(hit_a));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  task automatic learn(input string tag, input int p, input logic [47:0] mac);
    logic [3:0] oh;
    oh = 4'b0001 << p;
    RX_VALID = oh;
    RX_SRCMAC[p*48 +: 48] = mac;
    #1;
    chk({tag, ".rdy"}, rdy, oh);
    @(negedge i_clk);
    RX_VALID = '0;
  endtask

  task automatic tick();
    i_tick = 1'b1;
    @(negedge i_clk);
    i_tick = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic lookup(input string tag, input logic [47:0] mac, input logic [3:0] src,
                        input logic [3:0] exp_port, input logic exp_hit, input bit use_a);
    TX_VALID = 1'b1;
    TX_DSTMAC = mac;
    TX_SRCPORT = src;
    @(negedge i_clk);
    chk({tag, ".ack"},  use_a ? ack_a : ack, 1);
    chk({tag, ".port"}, use_a ? port_a : port, exp_port);
    chk({tag, ".hit"},  use_a ? hit_a : hit, exp_hit);
    @(negedge i_clk);
    chk({tag, ".ack2"}, use_a ? ack_a : ack, 0);
    TX_VALID = 1'b0;
    @(negedge i_clk);
  endtask

  initial begin
    i_reset = 1'b1; i_tick = 1'b0; i_flush = 1'b0;
    RX_VALID = '0; RX_SRCMAC = '0;
    TX_VALID = 1'b0; TX_DSTMAC = '0; TX_SRCPORT = '0;
    @(negedge i_clk);
    do_reset();
    chk("rst.ack", ack, 0);
    chk("rst.port", port, 0);
    chk("rst.hit", hit, 0);
    chk("rst.rdy", rdy, 0);

    // basic learn and lookup, plus hairpin drop
    learn("t1", 2, MAC_A);
    @(negedge i_clk);
    @(negedge i_clk);
    lookup("t1.hit", MAC_A, 4'b0001, 4'b0100, 1'b1, 1'b0);
    lookup("t1.hairpin", MAC_A, 4'b0100, 4'b0000, 1'b1, 1'b0);
    lookup("t1.miss", MAC_B, 4'b0010, 4'b1101, 1'b0, 1'b0);

    // round-robin with all ports requesting (multicast sources, not learned)
    do_reset();
    for (int k = 0; k < 4; k++) RX_SRCMAC[k*48 +: 48] = MAC_MC + 48'(k);
    RX_VALID = 4'hF;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("t2.gnt%0d", i), rdy, 4'b0001 << (i % 4));
      @(negedge i_clk);
    end
    RX_VALID = '0;
    lookup("t2.mc_not_learned", MAC_MC, 4'b0001, 4'b1110, 1'b0, 1'b0);

    // aging with AGEW=2
    do_reset();
    learn("t3", 2, MAC_A);
    tick();
    tick();
    lookup("t3.alive", MAC_A, 4'b0001, 4'b0100, 1'b1, 1'b1);
    tick();
    lookup("t3.aged", MAC_A, 4'b0001, 4'b1110, 1'b0, 1'b1);
    do_reset();
    learn("t3b", 2, MAC_A);
    tick();
    tick();
    learn("t3b.re", 2, MAC_A);
    tick();
    lookup("t3b.kept", MAC_A, 4'b0001, 4'b0100, 1'b1, 1'b1);

    // full table, least-age replacement
    do_reset();
    for (int i = 0; i < 64; i++) begin
      RX_VALID = 4'b0001 << (i % 4);
      RX_SRCMAC[(i % 4)*48 +: 48] = 48'h0200_0000_0000 + 48'(i);
      @(negedge i_clk);
    end
    RX_VALID = '0;
    tick();
    learn("t4.e0", 0, 48'h0200_0000_0000);
    learn("t4.b", 3, MAC_B);
    lookup("t4.b_hit", MAC_B, 4'b0001, 4'b1000, 1'b1, 1'b0);
    lookup("t4.e1_gone", 48'h0200_0000_0001, 4'b0001, 4'b1110, 1'b0, 1'b0);
    lookup("t4.e0_hit", 48'h0200_0000_0000, 4'b0010, 4'b0001, 1'b1, 1'b0);
    lookup("t4.e2_hit", 48'h0200_0000_0002, 4'b0001, 4'b0100, 1'b1, 1'b0);

    // broadcast / multicast destinations
    lookup("t5.bc", MAC_BC, 4'b0010, 4'b1101, 1'b0, 1'b0);
    lookup("t5.mc", MAC_MC, 4'b0010, 4'b1101, 1'b0, 1'b0);

    // station move, then flush colliding with a learn
    do_reset();
    learn("t6.p1", 1, MAC_A);
    lookup("t6.at1", MAC_A, 4'b0001, 4'b0010, 1'b1, 1'b0);
    learn("t6.p3", 3, MAC_A);
    lookup("t6.at3", MAC_A, 4'b0001, 4'b1000, 1'b1, 1'b0);
    i_flush = 1'b1;
    learn("t6.fl", 2, MAC_B);
    i_flush = 1'b0;
    lookup("t6.a_flushed", MAC_A, 4'b0001, 4'b1110, 1'b0, 1'b0);
    lookup("t6.b_dropped", MAC_B, 4'b0001, 4'b1110, 1'b0, 1'b0);
    chk("t6.port_hold", port, 4'b1110);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
